// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame sequencer:
// FSM states, TX output-mux select codes and parity type codes.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_PAR   = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter: loads a byte, presents bit 0,
// shifts right on shift_en and flags the last payload bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    output logic                  ser_bit,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_r;

    // Load wins over shift; the counter wraps to zero on the last bit so it is clear on exit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_r <= {DATA_WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load) begin
            shift_r <= load_data;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (shift_en) begin
            shift_r <= shift_r >> 1;
            cnt_r   <= done ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    assign ser_bit = shift_r[0];
    assign done    = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: START -> DATA (LSB first) -> [PARITY] -> STOP,
// driving the registered TX mux select, serial bit, parity bit and Busy.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  DATA_ACK,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  Busy
);

    function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] data, input logic typ);
        return (typ == PAR_ODD) ? ~(^data) : (^data);
    endfunction

    tx_state_e state_r;
    logic      par_en_r;
    logic      par_bit_r;
    logic [1:0] mux_sel_r;
    logic      busy_r;
    logic      accept_s;
    logic      shift_en_s;
    logic      done_s;
    logic      ser_bit_s;

    // Host request is taken only while idle or in the final stop cycle.
    always_comb begin
        accept_s = 1'b0;
        if (!RST && DATA_VALID && (state_r == ST_IDLE || state_r == ST_STOP)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign shift_en_s = (state_r == ST_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept_s),
        .load_data (P_DATA),
        .shift_en  (shift_en_s),
        .ser_bit   (ser_bit_s),
        .done      (done_s)
    );

    // Frame FSM; mux select and Busy are registered alongside the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            mux_sel_r <= SEL_STOP;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_STOP: begin
                    if (accept_s) begin
                        state_r   <= ST_START;
                        mux_sel_r <= SEL_START;
                        busy_r    <= 1'b1;
                        par_en_r  <= PAR_EN;
                        par_bit_r <= frame_parity(P_DATA, PAR_TYP);
                    end else begin
                        state_r   <= ST_IDLE;
                        mux_sel_r <= SEL_STOP;
                        busy_r    <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r   <= ST_DATA;
                    mux_sel_r <= SEL_DATA;
                end
                ST_DATA: begin
                    if (done_s && par_en_r) begin
                        state_r   <= ST_PARITY;
                        mux_sel_r <= SEL_PAR;
                    end else if (done_s) begin
                        state_r   <= ST_STOP;
                        mux_sel_r <= SEL_STOP;
                    end else begin
                        state_r   <= ST_DATA;
                        mux_sel_r <= SEL_DATA;
                    end
                end
                ST_PARITY: begin
                    state_r   <= ST_STOP;
                    mux_sel_r <= SEL_STOP;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mux_sel_r <= SEL_STOP;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_ACK = accept_s;
    assign MUX_SEL  = mux_sel_r;
    assign SER_DATA = ser_bit_s;
    assign PAR_BIT  = par_bit_r;
    assign Busy     = busy_r;

endmodule
